// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: one SEG-bit carry-lookahead slice
// per stage, inter-segment carry registered, valid/ready handshake, status flags.
module pipelined_addsub #(
  parameter int unsigned N   = 16,
  parameter int unsigned SEG = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero,
  output logic         neg
);

  localparam int unsigned L = N / SEG;

  // Stage registers. a_q/b_q carry the not-yet-consumed operand bits shifted
  // down to bit 0, so stage k always works on the low SEG bits of its input.
  logic         v_q [L];
  logic         c_q [L];
  logic [N-1:0] a_q [L];
  logic [N-1:0] b_q [L];
  logic [N-1:0] s_q [L];
  logic         ovf_q;
  logic         zero_q;
  logic         neg_q;

  logic         v_d [L];
  logic         c_d [L];
  logic [N-1:0] a_d [L];
  logic [N-1:0] b_d [L];
  logic [N-1:0] s_d [L];
  logic         ovf_d;
  logic         zero_d;
  logic         neg_d;

  logic         v_in [L];
  logic         c_in [L];
  logic [N-1:0] a_in [L];
  logic [N-1:0] b_in [L];
  logic [N-1:0] s_in [L];

  logic         adv;

  // Every carry is an independent sum of products of g/p and the carry-in.
  function automatic logic [SEG:0] lookahead(input logic [SEG-1:0] g,
                                             input logic [SEG-1:0] p,
                                             input logic           ci);
    logic [SEG:0] c;
    logic         term;
    c = '0;
    for (int unsigned i = 0; i <= SEG; i++) begin
      term = ci;
      for (int unsigned j = 0; j < i; j++) begin
        term = term & p[j];
      end
      c[i] = term;
      for (int unsigned j = 0; j < i; j++) begin
        term = g[j];
        for (int unsigned m = j + 1; m < i; m++) begin
          term = term & p[m];
        end
        c[i] = c[i] | term;
      end
    end
    return c;
  endfunction

  always_comb begin
    v_in[0] = in_valid;
    c_in[0] = sub;
    a_in[0] = a;
    b_in[0] = b ^ {N{sub}};
    s_in[0] = '0;
    for (int unsigned k = 1; k < L; k++) begin
      v_in[k] = v_q[k-1];
      c_in[k] = c_q[k-1];
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
    end
  end

  always_comb begin : stage_logic
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   cv;
    g  = '0;
    p  = '0;
    cv = '0;
    for (int unsigned k = 0; k < L; k++) begin
      g      = a_in[k][SEG-1:0] & b_in[k][SEG-1:0];
      p      = a_in[k][SEG-1:0] ^ b_in[k][SEG-1:0];
      cv     = lookahead(g, p, c_in[k]);
      v_d[k] = v_in[k];
      c_d[k] = cv[SEG];
      a_d[k] = a_in[k] >> SEG;
      b_d[k] = b_in[k] >> SEG;
      s_d[k] = s_in[k] | (N'(p ^ cv[SEG-1:0]) << (k * SEG));
    end
    // cv is left holding the final stage's carries, which feed overflow.
    ovf_d  = cv[SEG] ^ cv[SEG-1];
    zero_d = ~|s_d[L-1];
    neg_d  = s_d[L-1][N-1];
  end

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < L; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k < L; k++) begin
        v_q[k] <= v_d[k];
        c_q[k] <= c_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign out_valid = v_q[L-1];
  assign sum       = s_q[L-1];
  assign cout      = c_q[L-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule
